// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order retirement tracker for predicted branches.
// Decode allocates at the tail, execute resolves by tag in any order, and the
// head retires once resolved, driving the predictor update and mispredict flush.
module branch_resolve_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    input  logic [15:0]      alloc_pc,
    input  logic             alloc_pred,
    input  logic [15:0]      alloc_target,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             res_valid,
    input  logic [TAG_W-1:0] res_tag,
    input  logic             res_taken,
    input  logic [15:0]      res_target,
    output logic             old_br_rectify,
    output logic             old_br_result,
    output logic [15:0]      old_br_pc,
    output logic             flush_valid,
    output logic [15:0]      flush_pc,
    output logic [TAG_W-1:0] flush_tag
);

    localparam int unsigned PC_W  = 16;
    localparam int unsigned CNT_W = TAG_W + 1;

    // Control state (reset)
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] resolved_q;
    logic [TAG_W-1:0] head_q;
    logic [TAG_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    // Payload state (qualified by valid/resolved, no reset needed)
    logic [DEPTH-1:0] pred_q;
    logic [DEPTH-1:0] taken_q;
    logic [PC_W-1:0]  pc_q          [DEPTH];
    logic [PC_W-1:0]  pred_target_q [DEPTH];
    logic [PC_W-1:0]  target_q      [DEPTH];

    logic            retire;
    logic            head_mispredict;
    logic            retire_mispredict;
    logic            alloc_fire;
    logic            res_fire;
    logic            head_taken;
    logic [PC_W-1:0] head_pc;
    logic [PC_W-1:0] correct_pc;

    // Head retire decision and allocation handshake, from registered state only
    always_comb begin
        retire            = 1'b0;
        head_mispredict   = 1'b0;
        retire_mispredict = 1'b0;
        head_taken        = taken_q[head_q];
        head_pc           = pc_q[head_q];
        correct_pc        = head_pc + PC_W'(1);
        alloc_ready       = 1'b0;
        alloc_tag         = tail_q;
        alloc_fire        = 1'b0;
        res_fire          = 1'b0;

        retire = valid_q[head_q] && resolved_q[head_q];
        head_mispredict = (head_taken != pred_q[head_q]) ||
                          (head_taken && pred_q[head_q] &&
                           (target_q[head_q] != pred_target_q[head_q]));
        retire_mispredict = retire && head_mispredict;
        if (head_taken) begin
            correct_pc = target_q[head_q];
        end
        alloc_ready = (count_q != CNT_W'(DEPTH)) && !retire_mispredict;
        alloc_fire  = alloc_valid && alloc_ready;
        res_fire    = res_valid && valid_q[res_tag] && !retire_mispredict;
    end

    // Entry flags, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            resolved_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else if (retire_mispredict) begin
            valid_q    <= '0;
            resolved_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            if (res_fire) begin
                resolved_q[res_tag] <= 1'b1;
            end
            if (retire) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + TAG_W'(1);
            end
            if (alloc_fire) begin
                valid_q[tail_q]    <= 1'b1;
                resolved_q[tail_q] <= 1'b0;
                tail_q             <= tail_q + TAG_W'(1);
            end
            if (alloc_fire && !retire) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!alloc_fire && retire) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Entry payload capture on allocate and resolve
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            pc_q[tail_q]          <= alloc_pc;
            pred_q[tail_q]        <= alloc_pred;
            pred_target_q[tail_q] <= alloc_target;
        end
        if (res_fire) begin
            taken_q[res_tag]  <= res_taken;
            target_q[res_tag] <= res_target;
        end
    end

    // Predictor update and flush strobes, data held between pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            old_br_rectify <= 1'b0;
            old_br_result  <= 1'b0;
            old_br_pc      <= '0;
            flush_valid    <= 1'b0;
            flush_pc       <= '0;
            flush_tag      <= '0;
        end else begin
            old_br_rectify <= retire;
            flush_valid    <= retire_mispredict;
            if (retire) begin
                old_br_result <= head_taken;
                old_br_pc     <= head_pc;
            end
            if (retire_mispredict) begin
                flush_pc  <= correct_pc;
                flush_tag <= head_q;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue with hand-computed expectations.
module tb_branch_resolve_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_valid;
    logic [15:0] alloc_pc;
    logic        alloc_pred;
    logic [15:0] alloc_target;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        res_valid;
    logic [2:0]  res_tag;
    logic        res_taken;
    logic [15:0] res_target;
    logic        old_br_rectify;
    logic        old_br_result;
    logic [15:0] old_br_pc;
    logic        flush_valid;
    logic [15:0] flush_pc;
    logic [2:0]  flush_tag;

    int n_tests = 0;
    int n_fail  = 0;

    branch_resolve_queue #(.DEPTH(8), .TAG_W(3)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
        .alloc_target(alloc_target), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken),
        .res_target(res_target),
        .old_br_rectify(old_br_rectify), .old_br_result(old_br_result),
        .old_br_pc(old_br_pc), .flush_valid(flush_valid), .flush_pc(flush_pc),
        .flush_tag(flush_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        alloc_valid = 1'b0; alloc_pc = '0; alloc_pred = 1'b0; alloc_target = '0;
        res_valid = 1'b0; res_tag = '0; res_taken = 1'b0; res_target = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_alloc(input logic [15:0] pc, input logic pred, input logic [15:0] tgt);
        alloc_valid = 1'b1; alloc_pc = pc; alloc_pred = pred; alloc_target = tgt;
    endtask

    task automatic set_res(input logic [2:0] tag, input logic taken, input logic [15:0] tgt);
        res_valid = 1'b1; res_tag = tag; res_taken = taken; res_target = tgt;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check("rst_alloc_tag",   32'(alloc_tag),   32'd0);
        check("rst_rectify",     32'(old_br_rectify), 32'd0);
        check("rst_br_pc",       32'(old_br_pc),   32'd0);
        check("rst_flush",       32'(flush_valid), 32'd0);

        // Single correctly predicted taken branch
        set_alloc(16'h0010, 1'b1, 16'h0020);
        check("t1_alloc_tag", 32'(alloc_tag), 32'd0);
        tick();
        alloc_valid = 1'b0;
        set_res(3'd0, 1'b1, 16'h0020);
        tick();
        res_valid = 1'b0;
        check("t1_no_early_retire", 32'(old_br_rectify), 32'd0);
        tick();
        check("t1_rectify", 32'(old_br_rectify), 32'd1);
        check("t1_result",  32'(old_br_result),  32'd1);
        check("t1_pc",      32'(old_br_pc),      32'h0010);
        check("t1_flush",   32'(flush_valid),    32'd0);
        tick();
        check("t1_rectify_drop", 32'(old_br_rectify), 32'd0);
        check("t1_pc_hold",      32'(old_br_pc),      32'h0010);

        // Out-of-order resolve, in-order retire
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(16'(i), 1'b0, 16'h0000);
            check("t2_alloc_tag", 32'(alloc_tag), 32'(i));
            tick();
        end
        alloc_valid = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            set_res(3'(i), 1'b0, 16'h0000);
            tick();
            check("t2_no_pulse_yet", 32'(old_br_rectify), 32'd0);
        end
        res_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_rectify", 32'(old_br_rectify), 32'd1);
            check("t2_pc",      32'(old_br_pc),      32'(i));
        end
        tick();
        check("t2_rectify_end", 32'(old_br_rectify), 32'd0);

        // Fill, full refusal, drain one, wrap tag
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_alloc(16'h0100 + 16'(i), 1'b0, 16'h0000);
            check("t3_alloc_tag", 32'(alloc_tag), 32'(i));
            tick();
        end
        set_alloc(16'h0999, 1'b0, 16'h0000);
        check("t3_full_ready", 32'(alloc_ready), 32'd0);
        tick();
        check("t3_full_ready2", 32'(alloc_ready), 32'd0);
        check("t3_full_tag",    32'(alloc_tag),   32'd0);
        set_res(3'd0, 1'b0, 16'h0000);
        tick();
        res_valid = 1'b0;
        check("t3_ready_before_retire", 32'(alloc_ready), 32'd0);
        tick();
        check("t3_ready_after_retire", 32'(alloc_ready),    32'd1);
        check("t3_retire_rectify",     32'(old_br_rectify), 32'd1);
        check("t3_retire_pc",          32'(old_br_pc),      32'h0100);
        check("t3_wrap_tag",           32'(alloc_tag),      32'd0);
        tick();
        alloc_valid = 1'b0;
        check("t3_refull_ready", 32'(alloc_ready), 32'd0);
        check("t3_refull_tag",   32'(alloc_tag),   32'd1);

        // Not-taken mispredict with PC wrap, queue cleared
        do_reset();
        set_alloc(16'hFFFF, 1'b1, 16'h1234);
        tick();
        set_alloc(16'h0001, 1'b0, 16'h0000);
        tick();
        set_alloc(16'h0002, 1'b0, 16'h0000);
        tick();
        alloc_valid = 1'b0;
        set_res(3'd0, 1'b0, 16'h0000);
        tick();
        res_valid = 1'b0;
        check("t4_ready_during_mp", 32'(alloc_ready), 32'd0);
        tick();
        check("t4_flush_valid", 32'(flush_valid),    32'd1);
        check("t4_flush_pc",    32'(flush_pc),       32'h0000);
        check("t4_flush_tag",   32'(flush_tag),      32'd0);
        check("t4_result",      32'(old_br_result),  32'd0);
        check("t4_rectify",     32'(old_br_rectify), 32'd1);
        check("t4_br_pc",       32'(old_br_pc),      32'hFFFF);
        check("t4_alloc_tag",   32'(alloc_tag),      32'd0);
        check("t4_alloc_ready", 32'(alloc_ready),    32'd1);
        set_res(3'd1, 1'b0, 16'h0000);
        tick();
        res_valid = 1'b0;
        check("t4_flush_drop", 32'(flush_valid), 32'd0);
        tick();
        check("t4_stale_res_ignored", 32'(old_br_rectify), 32'd0);

        // Taken-target mismatch
        do_reset();
        set_alloc(16'h0050, 1'b1, 16'h0100);
        tick();
        alloc_valid = 1'b0;
        set_res(3'd0, 1'b1, 16'h0200);
        tick();
        res_valid = 1'b0;
        tick();
        check("t5_flush_valid", 32'(flush_valid),   32'd1);
        check("t5_flush_pc",    32'(flush_pc),      32'h0200);
        check("t5_result",      32'(old_br_result), 32'd1);

        // Same scenario, reset lands on the retire edge
        do_reset();
        set_alloc(16'h0050, 1'b1, 16'h0100);
        tick();
        alloc_valid = 1'b0;
        set_res(3'd0, 1'b1, 16'h0200);
        tick();
        res_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rectify",     32'(old_br_rectify), 32'd0);
        check("t6_flush",       32'(flush_valid),    32'd0);
        check("t6_alloc_ready", 32'(alloc_ready),    32'd1);
        tick();
        check("t6_rectify_late", 32'(old_br_rectify), 32'd0);
        check("t6_flush_late",   32'(flush_valid),    32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
